// File: rtl/ln_pkg.sv
// Shared widths, FSM encoding and saturation helper for the LayerNorm variance/normalise stage.
package ln_pkg;

  localparam int Q88_W   = 16;
  localparam int Q1616_W = 32;
  localparam int LANES   = 16;
  localparam int ACC_W   = 36;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACC,
    ST_RSQRT,
    ST_NORM,
    ST_OUT
  } state_t;

  function automatic logic signed [Q88_W-1:0] sat16(input logic signed [31:0] v);
    if (v > 32'sd32767)       return 16'sh7FFF;
    else if (v < -32'sd32768) return 16'sh8000;
    else                      return v[Q88_W-1:0];
  endfunction

endpackage

// File: rtl/ln_lod32.sv
// Combinational 32-bit leading-one detector: index of the highest set bit plus an all-zero flag.
module ln_lod32 (
  input  logic [31:0] value,
  output logic [4:0]  idx,
  output logic        zero
);

  always_comb begin
    idx = '0;
    for (int i = 0; i < 32; i++) begin
      if (value[i]) idx = 5'(i);
    end
  end

  assign zero = (value == '0);

endmodule

// File: rtl/ln_var_norm.sv
// Serial population variance and power-of-two 1/sqrt normalisation of a 16-lane Q8.8 vector.
// Optional 0.75x odd-exponent correction enabled by defining LN_MANT_CORR_EN.
module ln_var_norm
  import ln_pkg::*;
#(
  parameter int N   = 16,
  parameter int EPS = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N*Q88_W-1:0]     x_in_flat,
  input  logic [Q88_W-1:0]       mean_in,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [N*Q88_W-1:0]     y_out_flat,
  output logic [Q1616_W-1:0]     var_out,
  output logic                   out_valid,
  input  logic                   out_ready
);

`ifdef LN_MANT_CORR_EN
  localparam bit CORR_EN = 1'b1;
`else
  localparam bit CORR_EN = 1'b0;
`endif

  state_t state_q, state_d;

  logic [3:0]               lane_q;
  logic signed [Q88_W-1:0]  x_buf [LANES];
  logic signed [Q88_W-1:0]  y_buf [LANES];
  logic signed [Q88_W-1:0]  mean_q;
  logic [ACC_W-1:0]         acc_q;
  logic [Q1616_W-1:0]       var_q;
  logic signed [4:0]        shift_q;
  logic                     zero_q;
  logic                     corr_q;

  logic signed [Q88_W-1:0]  x_cur;
  logic signed [16:0]       dev17;
  logic signed [Q88_W-1:0]  dev16;
  logic signed [31:0]       prod;
  logic [Q1616_W-1:0]       var_next;
  logic [4:0]               lod_idx;
  logic                     lod_zero;
  logic signed [5:0]        k;
  logic [4:0]               lshamt;
  logic signed [31:0]       y_wide;
  logic signed [Q88_W-1:0]  y_lane;

  assign x_cur    = x_buf[lane_q];
  assign dev17    = $signed({x_cur[15], x_cur}) - $signed({mean_q[15], mean_q});
  assign dev16    = sat16(32'(dev17));
  assign prod     = dev16 * dev16;
  assign var_next = acc_q[ACC_W-1:4] + 32'(EPS);
  assign k        = $signed({1'b0, lod_idx}) - 6'sd16;
  assign lshamt   = 5'd0 - shift_q;

  ln_lod32 u_lod (
    .value (var_next),
    .idx   (lod_idx),
    .zero  (lod_zero)
  );

  // During NORM the lane buffer holds the saturated deviation, not the raw input.
  always_comb begin
    // NOTE: every combinational result gets a default first so no path can infer a latch.
    y_wide = 32'(x_cur);
    if (shift_q[4]) y_wide = y_wide <<< lshamt;
    else            y_wide = y_wide >>> shift_q[3:0];
    if (corr_q)     y_wide = y_wide - (y_wide >>> 2);
    y_lane = zero_q ? '0 : sat16(y_wide);
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (in_valid)        state_d = ST_ACC;
      ST_ACC:   if (lane_q == 4'd15) state_d = ST_RSQRT;
      ST_RSQRT:                      state_d = ST_NORM;
      ST_NORM:  if (lane_q == 4'd15) state_d = ST_OUT;
      ST_OUT:   if (out_ready)       state_d = ST_IDLE;
      default:                       state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_OUT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lane_q  <= '0;
      mean_q  <= '0;
      acc_q   <= '0;
      var_q   <= '0;
      shift_q <= '0;
      zero_q  <= 1'b0;
      corr_q  <= 1'b0;
      // NOTE: the lane buffers are cleared too, so outputs read zero after a reset even mid-vector.
      for (int i = 0; i < LANES; i++) begin
        x_buf[i] <= '0;
        y_buf[i] <= '0;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            for (int i = 0; i < LANES; i++) x_buf[i] <= x_in_flat[Q88_W*i +: Q88_W];
            mean_q <= mean_in;
            acc_q  <= '0;
            lane_q <= '0;
          end
        end
        ST_ACC: begin
          x_buf[lane_q] <= dev16;
          acc_q         <= acc_q + {4'b0000, prod};
          lane_q        <= lane_q + 4'd1;
        end
        ST_RSQRT: begin
          var_q   <= var_next;
          shift_q <= k[5:1];
          zero_q  <= lod_zero;
          corr_q  <= CORR_EN && k[0];
          lane_q  <= '0;
        end
        ST_NORM: begin
          y_buf[lane_q] <= y_lane;
          lane_q        <= lane_q + 4'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < LANES; i++) y_out_flat[Q88_W*i +: Q88_W] = y_buf[i];
  end

  assign var_out = var_q;

endmodule

// File: tb/tb_ln_var_norm.sv
// Directed bench for ln_var_norm: hand-computed variances, normalised lanes, latency, back-pressure, reset.
module tb_ln_var_norm;

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] x_in_flat;
  logic [15:0]  mean_in;
  logic         in_valid;
  logic         in_ready;
  logic [255:0] y_out_flat;
  logic [31:0]  var_out;
  logic         out_valid;
  logic         out_ready;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ln_var_norm dut (
    .clk        (clk),
    .rst        (rst),
    .x_in_flat  (x_in_flat),
    .mean_in    (mean_in),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .y_out_flat (y_out_flat),
    .var_out    (var_out),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] alt(input logic [15:0] a, input logic [15:0] b);
    logic [255:0] v;
    for (int i = 0; i < 16; i++) v[16*i +: 16] = (i % 2 == 0) ? a : b;
    return v;
  endfunction

  // Present one vector on a falling edge once in_ready is seen; transfer on the next rising edge.
  task automatic send(input string tag, input logic [255:0] x, input logic [15:0] m);
    int waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    x_in_flat = x;
    mean_in   = m;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    x_in_flat = '1;
    mean_in   = 16'h1234;
  endtask

  // Counts falling edges after the transfer edge until out_valid is seen; 999 on timeout.
  task automatic wait_out(output int lat);
    lat = 0;
    while (lat < 100) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
    end
    if (!out_valid) lat = 999;
  endtask

  task automatic check_result(input string tag, input logic [255:0] exp_y, input logic [31:0] exp_var);
    check({tag, "_var"}, var_out, exp_var);
    for (int i = 0; i < 16; i++)
      check($sformatf("%s_y%0d", tag, i), 32'(y_out_flat[16*i +: 16]), 32'(exp_y[16*i +: 16]));
  endtask

  task automatic accept(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check({tag, "_done_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_done_ready"}, 32'(in_ready), 32'd1);
  endtask

  task automatic run_vector(input string tag, input logic [255:0] x, input logic [15:0] m,
                            input logic [255:0] exp_y, input logic [31:0] exp_var);
    int lat;
    send(tag, x, m);
    wait_out(lat);
    check({tag, "_latency"}, 32'(lat), 32'd34);
    check_result(tag, exp_y, exp_var);
    accept(tag);
  endtask

  logic [255:0] x5, y5, y4, y_hold;
  logic [31:0]  v_hold;
  int           lat;

  initial begin
    rst       = 1'b1;
    x_in_flat = '0;
    mean_in   = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready",  32'(in_ready),     32'd1);
    check("rst_out_valid", 32'(out_valid),    32'd0);
    check("rst_var",       var_out,           32'd0);
    check("rst_y_zero",    32'(|y_out_flat),  32'd0);

    // Zero deviation: var is just EPS, s = -8, every y is 0.
    run_vector("t1", alt(16'h0100, 16'h0100), 16'h0100, '0, 32'h0000_0001);

    // |dev| = 1.0: var = 1.0 + EPS, s = 0.
    run_vector("t2", alt(16'h0100, 16'hFF00), 16'h0000, alt(16'h0100, 16'hFF00), 32'h0001_0001);

    // |dev| = 2.0: var = 4.0 + EPS, k = 2, s = 1.
    run_vector("t3", alt(16'h0200, 16'hFE00), 16'h0000, alt(16'h0100, 16'hFF00), 32'h0004_0001);

    // |dev| = 1.5: var = 2.25 + EPS, k = 1 (odd), s = 0.
`ifdef LN_MANT_CORR_EN
    y4 = alt(16'h0120, 16'hFEE0);
`else
    y4 = alt(16'h0180, 16'hFE80);
`endif
    run_vector("t4", alt(16'h0180, 16'hFE80), 16'h0000, y4, 32'h0002_4001);

    // Lane 0 deviation saturates to 0x7FFF: var = 0x03FFF001, p = 25, k = 9, s = 4.
    x5 = alt(16'h8000, 16'h8000);
    x5[15:0] = 16'h7F00;
    y5 = '0;
`ifdef LN_MANT_CORR_EN
    y5[15:0] = 16'h0600;
`else
    y5[15:0] = 16'h07FF;
`endif
    run_vector("t5", x5, 16'h8000, y5, 32'h03FF_F001);

    // Back-pressure: result held for 10 cycles while a second vector is offered and ignored.
    send("bp", alt(16'h0200, 16'hFE00), 16'h0000);
    wait_out(lat);
    check("bp_latency", 32'(lat), 32'd34);
    y_hold = y_out_flat;
    v_hold = var_out;
    x_in_flat = alt(16'h0180, 16'hFE80);
    mean_in   = 16'h0000;
    in_valid  = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready",  32'(in_ready),  32'd0);
      check("bp_y_stable",  32'(y_out_flat == y_hold), 32'd1);
      check("bp_var_stable", var_out, v_hold);
    end
    in_valid = 1'b0;
    check_result("bp", alt(16'h0100, 16'hFF00), 32'h0004_0001);
    accept("bp");

    // Reset in the middle of ACC, then a fresh vector must complete normally.
    send("rs", x5, 16'h8000);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rs_in_ready",  32'(in_ready),    32'd1);
    check("rs_out_valid", 32'(out_valid),   32'd0);
    check("rs_var",       var_out,          32'd0);
    check("rs_y_zero",    32'(|y_out_flat), 32'd0);
    run_vector("rs2", alt(16'h0100, 16'hFF00), 16'h0000, alt(16'h0100, 16'hFF00), 32'h0001_0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ln_var_norm.md
Name: ln_var_norm

Overview:
- Stage directly downstream of the 16-lane LayerNorm mean adder tree.
- Takes one 16-element signed Q8.8 vector plus its Q8.8 mean, then serially computes the population variance.
- Derives a power-of-two approximation of 1/sqrt(var + EPS) and emits the 16 normalized elements as signed Q8.8.
- Valid/ready on both sides; one vector in flight at a time.

Parameters:
- N, 16, lanes per vector; fixed at 16 (variance is acc >> 4).
- EPS, 1, epsilon added to variance, in Q16.16 LSBs.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- x_in_flat  in  256  16 signed Q8.8 elements; lane i = bits [16i+15:16i]
- mean_in  in  16  signed Q8.8 mean of x_in_flat, from the mean stage
- in_valid  in  1  input vector + mean valid
- in_ready  out  1  block can accept a vector
- y_out_flat  out  256  16 normalized signed Q8.8 elements, same lane packing
- var_out  out  32  unsigned Q16.16 variance, including EPS
- out_valid  out  1  y_out_flat/var_out valid
- out_ready  in  1  downstream accepts

Behaviour:
- Reset: state IDLE; in_ready=1; out_valid=0; y_out_flat=0; var_out=0; accumulator and buffers cleared. rst wins over every other event, including mid-vector.
- Handshake: transfer when in_valid&&in_ready at a clk edge.
  - in_ready=1 only in IDLE.
  - x_in_flat and mean_in are captured into internal registers at transfer; inputs may change afterwards.
- FSM: IDLE -> ACC -> RSQRT -> NORM -> OUT -> IDLE.
  - ACC (16 cycles, lane 0..15, 4-bit counter):
    - dev = x[i] - mean, 17-bit signed.
    - Saturate dev to 16-bit signed [0x8000, 0x7FFF] and store it back into the lane buffer.
    - sq = dev*dev, 32-bit unsigned Q16.16.
    - acc += sq, 36-bit accumulator.
  - RSQRT (1 cycle):
    - var = (acc >> 4) + EPS, 32-bit.
    - p = index of the leading one of var (0..30).
    - k = p - 16.
    - s = k >>> 1 (floor, range -8..7).
    - If var == 0 (only possible with EPS=0), the zero flag forces all y to 0.
  - NORM (16 cycles, lane 0..15):
    - y = dev >>> s if s >= 0.
    - y = dev << -s if s < 0, saturated to 16-bit signed.
    - Result is written to the output buffer.
  - OUT: out_valid=1, with y_out_flat and var_out held stable until out_valid&&out_ready. The next cycle is IDLE with out_valid=0.
- Latency: out_valid rises exactly 34 cycles after the input transfer edge when the optional feature is off (16 ACC + 1 RSQRT + 16 NORM + 1).
- Back-pressure: the block holds in OUT indefinitely; no new input is accepted in that state.
- No pass-through: the minimum accepted-vector spacing is 35 cycles.

Optional Feature:
- LN_MANT_CORR_EN defined:
  - In RSQRT, odd k sets a corr flag.
  - In NORM, y_corr = y - (y >>> 2), i.e. y x 0.75 as a 1/sqrt2 approximation, before final saturation.
  - Latency is unchanged.
- Not defined: no correction; y is the pure shifted deviation.

Decomposition:
- Shared package ln_pkg:
  - Q8.8 width (16), Q16.16 width (32), lane count 16, accumulator width 36.
  - FSM state encoding: IDLE, ACC, RSQRT, NORM, OUT.
  - Saturation helper function for 16-bit signed.
- One sub-module: ln_lod32, a combinational 32-bit leading-one detector returning the 5-bit index and a zero flag, used in RSQRT.

Test Plan:
1. All x=0x0100, mean=0x0100:
   - dev 0, var_out=0x00000001, p=0, s=-8.
   - All y=0x0000; out_valid exactly 34 cycles after transfer.
2. x alternating 0x0100/0xFF00, mean=0x0000:
   - var_out=0x00010001, s=0.
   - y alternates 0x0100/0xFF00.
3. x alternating 0x0200/0xFE00, mean=0:
   - var_out=0x00040001, k=2, s=1.
   - y alternates 0x0100/0xFF00.
4. x alternating 0x0180/0xFE80, mean=0:
   - var_out=0x00024001, k=1, s=0.
   - Without LN_MANT_CORR_EN, y=±0x0180.
   - With LN_MANT_CORR_EN, y=0x0120/0xFEE0.
5. x[0]=0x7F00, others 0x8000, mean=0x8000:
   - dev0 saturates to 0x7FFF; var_out=0x03FFF001, p=25, s=4.
   - y[0]=0x07FF, others 0.
6. Handshake and reset:
   - Hold out_ready=0 for 10 cycles: out_valid and y stay stable and in_ready stays 0; a second in_valid is ignored.
   - Assert rst during ACC: the next cycle is IDLE, in_ready=1, out_valid=0, and a fresh vector then completes correctly.
